vec_alu_vv_pipe: RTL and testbench
==================================

Name: vec_alu_vv_pipe

Overview:
Parametrised, pipelined vector-vector ALU for the ALUe execute stage.
- Splits two packed vector operands into LANES independent lanes of LANE_W bits.
- Applies one of eight element-wise operations selected by funct, with a per-lane write mask.
- Returns the packed result through a 2-stage valid/ready pipeline that accepts one vector per cycle.
- Generalises the fixed 24x8-bit adder with widths, sub/saturate/min/max modes, masking and flow control.

Parameters:
LANES, 24, number of vector elements
LANE_W, 8, bits per element (legal 2..64)
VEC_W, LANES*LANE_W, derived packed vector width; do not override

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand vector present
in_ready  out  1  stage 1 can accept
op1  in  VEC_W  operand A; lane i = bits [i*LANE_W +: LANE_W]
op2  in  VEC_W  operand B, same packing
funct  in  3  operation select
mask  in  LANES  1 = lane computed, 0 = lane passes op1 unchanged
out_valid  out  1  result vector present
out_ready  in  1  consumer accepts
result  out  VEC_W  packed result

Behaviour:
- Reset: rst_n low at a rising edge clears s1_valid, s2_valid, out_valid and result to 0. in_ready reads 1 in the cycle after reset. Reset mid-operation discards all in-flight vectors.
- Handshake:
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | (s2_valid_next_load).
  - in_ready = !s1_valid | s2_adv, combinational, with no dependency on in_valid.
- Stage 1 loads op1/op2/funct/mask on input fire. s1_valid is set on fire, and cleared when s1 moves to s2 without a new fire.
- Stage 2 computes the lane results from stage-1 registers and loads result when s1_valid & s2_adv. out_valid = s2_valid.
- Latency: 2 cycles from input fire to out_valid with out_ready held high. Throughput is 1 vector/cycle.
- Stall: out_valid & !out_ready holds result stable. A second vector may sit in s1. in_ready drops only when both stages are full and out_ready is low.
- Simultaneous output fire and input fire with both stages full: shift without a bubble, no loss, no duplication.
- Data registers change only on a load. Valid bits alone gate visibility.
- funct per lane (a = op1 lane, b = op2 lane; results are LANE_W bits):
  - 000 add: a+b mod 2^LANE_W.
  - 001 sub: a-b mod 2^LANE_W.
  - 010 unsigned saturating add: clamps at 2^LANE_W-1.
  - 011 unsigned saturating sub: clamps at 0.
  - 100 signed saturating add: two's complement; clamps at max positive / min negative.
  - 101 signed saturating sub: same clamping.
  - 110 unsigned min.
  - 111 unsigned max.
- No carry crosses lane boundaries under any funct.
- mask[i]=0: result lane i = a, regardless of funct.

Optional Feature:
VEC_ALU_OVF_FLAGS_EN
- Defined:
  - Adds output ovf [LANES-1:0], registered alongside result with identical valid/stall timing; reset value 0.
  - ovf[i]=1 when lane i's unmasked op overflowed or saturated: carry-out for 000/010, borrow for 001/011, signed overflow for 100/101.
  - ovf[i] is always 0 for 110/111 and for masked lanes.
- Undefined: the port does not exist and no flag logic is built. Result behaviour is identical in both builds.

Test Plan:
1. Defaults. funct=000, all lanes a=0xF0, b=0x20, mask all 1, out_ready=1 -> result all lanes 0x10 two cycles after fire; ovf all 1 if enabled; lane 5 (bits 47:40) verified independently to catch lane-boundary slicing errors.
2. funct=010, a=0xF0, b=0x20 -> 0xFF. funct=011, a=0x10, b=0x20 -> 0x00. funct=100, a=0x7F, b=0x01 -> 0x7F. funct=101, a=0x80, b=0x01 -> 0x80.
3. funct=111, a=0x05, b=0x09 -> 0x09. funct=110 on the same operands -> 0x05. mask=0 on lane 0 only -> lane 0 = 0x05 under both functs.
4. Backpressure. Stream 4 vectors tagged lane0 = 1..4 with out_ready=0 for 5 cycles:
   - in_ready falls after 2 accepts.
   - result holds tag 1.
   - After release, tags 1,2,3,4 emerge in order on consecutive cycles with no loss or duplication.
5. Full-throughput stream with in_valid and out_ready constantly 1, 10 vectors -> 10 outputs on 10 consecutive cycles, first at fire+2.
6. Reset during a stall. Assert rst_n=0 for 1 cycle with both stages full -> out_valid=0 and result=0 next cycle, in_ready=1, old vectors never appear.
7. Parameter build LANES=4, LANE_W=16, funct=000, a=0xFFFF, b=0x0001 -> 0x0000 per lane, no carry into the neighbouring lane.

Source files
------------

// File: rtl/vec_alu_vv_pipe_if.sv
// vec_alu_vv_pipe_if: operand/result valid-ready bundle for vec_alu_vv_pipe.
// VEC_ALU_OVF_FLAGS_EN adds the per-lane ovf flag vector.
interface vec_alu_vv_pipe_if #(
    parameter int LANES  = 24,
    parameter int LANE_W = 8,
    parameter int VEC_W  = LANES * LANE_W
);
    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] op1;
    logic [VEC_W-1:0] op2;
    logic [2:0]       funct;
    logic [LANES-1:0] mask;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] result;
`ifdef VEC_ALU_OVF_FLAGS_EN
    logic [LANES-1:0] ovf;
    modport master (output in_valid, op1, op2, funct, mask, out_ready,
                    input in_ready, out_valid, result, ovf);
    modport slave (input in_valid, op1, op2, funct, mask, out_ready,
                   output in_ready, out_valid, result, ovf);
`else
    modport master (output in_valid, op1, op2, funct, mask, out_ready,
                    input in_ready, out_valid, result);
    modport slave (input in_valid, op1, op2, funct, mask, out_ready,
                   output in_ready, out_valid, result);
`endif
endinterface

// File: rtl/vec_alu_vv_pipe.sv
// vec_alu_vv_pipe: 2-stage valid/ready vector ALU, LANES x LANE_W lanes, eight element-wise ops.
// Define VEC_ALU_OVF_FLAGS_EN to add registered per-lane overflow/saturation flags.
module vec_alu_vv_pipe #(
    parameter int LANES  = 24,
    parameter int LANE_W = 8,
    parameter int VEC_W  = LANES * LANE_W
) (
    input logic              clk,
    input logic              rst_n,
    vec_alu_vv_pipe_if.slave bus
);
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [VEC_W-1:0] op1_q, op1_d, op2_q, op2_d, result_q, result_d, lane_res;
    logic [2:0]       funct_q, funct_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic             s2_adv, s2_load, in_fire;

    always_comb begin
        s2_adv     = !s2_valid_q || bus.out_ready;
        s2_load    = s1_valid_q && s2_adv;
        in_fire    = bus.in_valid && (!s1_valid_q || s2_adv);
        s1_valid_d = in_fire || (s1_valid_q && !s2_load);
        s2_valid_d = s2_load || (s2_valid_q && !bus.out_ready);
        op1_d      = in_fire ? bus.op1 : op1_q;
        op2_d      = in_fire ? bus.op2 : op2_q;
        funct_d    = in_fire ? bus.funct : funct_q;
        mask_d     = in_fire ? bus.mask : mask_q;
        result_d   = s2_load ? lane_res : result_q;
    end

    assign bus.in_ready  = !s1_valid_q || s2_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = result_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        op1_q   <= op1_d;
        op2_q   <= op2_d;
        funct_q <= funct_d;
        mask_q  <= mask_d;
    end

`ifdef VEC_ALU_OVF_FLAGS_EN
    logic [LANES-1:0] lane_ovf, ovf_q, ovf_d;
`endif

    // Each lane computes in LANE_W+1 bits so carries/borrows never reach a neighbour.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] a, b, sat, r;
        logic [LANE_W:0]   sum, diff;
        logic              sov_add, sov_sub;
        always_comb begin
            a       = op1_q[i*LANE_W +: LANE_W];
            b       = op2_q[i*LANE_W +: LANE_W];
            sum     = {1'b0, a} + {1'b0, b};
            diff    = {1'b0, a} - {1'b0, b};
            sov_add = (a[LANE_W-1] == b[LANE_W-1]) && (sum[LANE_W-1] != a[LANE_W-1]);
            sov_sub = (a[LANE_W-1] != b[LANE_W-1]) && (diff[LANE_W-1] != a[LANE_W-1]);
            sat     = a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
            r       = funct_q == 3'd0 ? sum[LANE_W-1:0] :
                      funct_q == 3'd1 ? diff[LANE_W-1:0] :
                      funct_q == 3'd2 ? (sum[LANE_W] ? {LANE_W{1'b1}} : sum[LANE_W-1:0]) :
                      funct_q == 3'd3 ? (diff[LANE_W] ? {LANE_W{1'b0}} : diff[LANE_W-1:0]) :
                      funct_q == 3'd4 ? (sov_add ? sat : sum[LANE_W-1:0]) :
                      funct_q == 3'd5 ? (sov_sub ? sat : diff[LANE_W-1:0]) :
                      funct_q == 3'd6 ? ((a < b) ? a : b) :
                                        ((a < b) ? b : a);
        end
        assign lane_res[i*LANE_W +: LANE_W] = mask_q[i] ? r : a;
`ifdef VEC_ALU_OVF_FLAGS_EN
        assign lane_ovf[i] = mask_q[i] && !(funct_q[2] && funct_q[1]) &&
                             (funct_q[2] ? (funct_q[0] ? sov_sub : sov_add)
                                         : (funct_q[0] ? diff[LANE_W] : sum[LANE_W]));
`endif
    end

`ifdef VEC_ALU_OVF_FLAGS_EN
    always_comb ovf_d = s2_load ? lane_ovf : ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= '0;
        else ovf_q <= ovf_d;
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_vec_alu_vv_pipe.sv
// tb_vec_alu_vv_pipe: directed checks of vec_alu_vv_pipe (24x8 default build plus a 4x16 instance).
module tb_vec_alu_vv_pipe;
    localparam int L = 24;
    localparam int W = 8;
    localparam int V = L * W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vec_alu_vv_pipe_if #(.LANES(L), .LANE_W(W)) bus ();
    vec_alu_vv_pipe #(.LANES(L), .LANE_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    vec_alu_vv_pipe_if #(.LANES(4), .LANE_W(16)) bus2 ();
    vec_alu_vv_pipe #(.LANES(4), .LANE_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic chk(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [V-1:0] a, input logic [V-1:0] b,
                         input logic [2:0] f, input logic [L-1:0] m);
        bus.in_valid = v;
        bus.op1      = a;
        bus.op2      = b;
        bus.funct    = f;
        bus.mask     = m;
    endtask

    task automatic send(input logic [V-1:0] a, input logic [V-1:0] b,
                        input logic [2:0] f, input logic [L-1:0] m);
        drive(1'b1, a, b, f, m);
        tick;
        bus.in_valid = 1'b0;
        tick;
    endtask

    function automatic logic [V-1:0] tv(input int t);
        return V'(t);
    endfunction

    initial begin
        drive(1'b0, '0, '0, 3'd0, '1);
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.op1       = '0;
        bus2.op2       = '0;
        bus2.funct     = 3'd0;
        bus2.mask      = '1;
        bus2.out_ready = 1'b1;
        tick;
        tick;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_result", bus.result, '0);
        rst_n = 1'b1;
        tick;
        chk1("rst_in_ready", bus.in_ready, 1'b1);

        // 1: wrapping add, plus an independent look at lane 5
        send({L{8'hF0}}, {L{8'h20}}, 3'd0, '1);
        chk1("add_valid", bus.out_valid, 1'b1);
        chk("add_result", bus.result, {L{8'h10}});
        chk("add_lane5", V'(bus.result[47:40]), V'(8'h10));
`ifdef VEC_ALU_OVF_FLAGS_EN
        chk("add_ovf", V'(bus.ovf), V'({L{1'b1}}));
`endif

        // 2: saturating modes
        send({L{8'hF0}}, {L{8'h20}}, 3'd2, '1);
        chk("usat_add", bus.result, {L{8'hFF}});
        send({L{8'h10}}, {L{8'h20}}, 3'd3, '1);
        chk("usat_sub", bus.result, {L{8'h00}});
        send({L{8'h7F}}, {L{8'h01}}, 3'd4, '1);
        chk("ssat_add", bus.result, {L{8'h7F}});
        send({L{8'h80}}, {L{8'h01}}, 3'd5, '1);
        chk("ssat_sub", bus.result, {L{8'h80}});
`ifdef VEC_ALU_OVF_FLAGS_EN
        chk("ssat_sub_ovf", V'(bus.ovf), V'({L{1'b1}}));
`endif
        send({L{8'h20}}, {L{8'h10}}, 3'd5, '1);
        chk("ssat_sub_plain", bus.result, {L{8'h10}});

        // 3: min/max and masking
        send({L{8'h05}}, {L{8'h09}}, 3'd7, '1);
        chk("umax", bus.result, {L{8'h09}});
`ifdef VEC_ALU_OVF_FLAGS_EN
        chk("umax_ovf", V'(bus.ovf), '0);
`endif
        send({L{8'h05}}, {L{8'h09}}, 3'd6, '1);
        chk("umin", bus.result, {L{8'h05}});
        send({L{8'h05}}, {L{8'h09}}, 3'd7, {{(L-1){1'b1}}, 1'b0});
        chk("umax_mask0", bus.result, {{(L-1){8'h09}}, 8'h05});
        send({L{8'h05}}, {L{8'h09}}, 3'd6, {{(L-1){1'b1}}, 1'b0});
        chk("umin_mask0", bus.result, {L{8'h05}});

        // 4: backpressure with four tagged vectors
        tick;
        bus.out_ready = 1'b0;
        drive(1'b1, tv(1), '0, 3'd0, '1);
        tick;
        drive(1'b1, tv(2), '0, 3'd0, '1);
        tick;
        chk1("bp_in_ready_low", bus.in_ready, 1'b0);
        chk1("bp_valid", bus.out_valid, 1'b1);
        chk("bp_hold_tag1", bus.result, tv(1));
        drive(1'b1, tv(3), '0, 3'd0, '1);
        tick;
        tick;
        tick;
        chk("bp_still_tag1", bus.result, tv(1));
        chk1("bp_still_blocked", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        chk1("bp_release_ready", bus.in_ready, 1'b1);
        tick;
        chk("bp_tag2", bus.result, tv(2));
        drive(1'b1, tv(4), '0, 3'd0, '1);
        tick;
        chk("bp_tag3", bus.result, tv(3));
        bus.in_valid = 1'b0;
        tick;
        chk1("bp_tag4_valid", bus.out_valid, 1'b1);
        chk("bp_tag4", bus.result, tv(4));
        tick;
        chk1("bp_drained", bus.out_valid, 1'b0);

        // 5: full-throughput stream of ten vectors
        for (int k = 1; k <= 11; k++) begin
            if (k <= 10) drive(1'b1, tv(k), '0, 3'd0, '1);
            else bus.in_valid = 1'b0;
            chk1("stream_in_ready", bus.in_ready, 1'b1);
            tick;
            if (k >= 2) begin
                chk1("stream_valid", bus.out_valid, 1'b1);
                chk("stream_tag", bus.result, tv(k - 1));
            end
        end
        tick;
        chk1("stream_end", bus.out_valid, 1'b0);

        // 6: reset with both stages full and output stalled
        bus.out_ready = 1'b0;
        drive(1'b1, tv(8'h55), '0, 3'd0, '1);
        tick;
        drive(1'b1, tv(8'h66), '0, 3'd0, '1);
        tick;
        bus.in_valid = 1'b0;
        chk1("full_in_ready", bus.in_ready, 1'b0);
        chk1("full_valid", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        tick;
        chk1("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_result", bus.result, '0);
        chk1("mid_rst_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk1("post_rst_quiet", bus.out_valid, 1'b0);
        end

        // 7: 4x16 build, carries must stay inside their lane
        bus2.op1      = {4{16'hFFFF}};
        bus2.op2      = {4{16'h0001}};
        bus2.in_valid = 1'b1;
        tick;
        bus2.in_valid = 1'b0;
        tick;
        chk1("w16_valid", bus2.out_valid, 1'b1);
        chk("w16_wrap", V'(bus2.result), '0);
`ifdef VEC_ALU_OVF_FLAGS_EN
        chk("w16_ovf", V'(bus2.ovf), V'(4'hF));
`endif
        bus2.op1      = {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        bus2.in_valid = 1'b1;
        tick;
        bus2.in_valid = 1'b0;
        tick;
        chk("w16_no_carry", V'(bus2.result), V'({16'h0001, 16'h0000, 16'h0001, 16'h0000}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
